russian_peasant_seq_multiplier: RTL and testbench
=================================================

# russian_peasant_seq_multiplier

Iterative, parametrised unsigned shift-and-add ("Russian peasant") multiplier. It consumes K multiplier bits per cycle and terminates early once the remaining multiplier is zero. Trading latency for area, it sits beside the single-cycle tree multipliers and serves datapaths where the product is not needed in one cycle. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- WIDTH, default 8: operand width in bits; must be ≥ 2.
- DIGIT, default 1: multiplier bits retired per cycle; must divide WIDTH; legal values 1, 2, 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplier, unsigned.
- b  input  WIDTH  multiplicand, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, unsigned, full width with no truncation.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, load acc=0, mcand=zero-extended b (2*WIDTH), mplier=a, then go to RUN.
- RUN: one step per cycle.
  - Form the sum of the DIGIT partial products: mcand<<i where mplier[i]=1, for i=0..DIGIT-1.
  - Update acc += that sum (mod 2^(2*WIDTH); the final value never overflows).
  - Then mcand <<= DIGIT and mplier >>= DIGIT.
  - If the post-shift mplier==0, go to DONE; otherwise stay in RUN.
- DONE:
  - out_valid=1 and product=acc; both are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. There is no overlap of operations and no acceptance in the same cycle as out_ready.
- a=0 or b=0 needs no special path. a=0 takes exactly one RUN step and produces 0.
- The product register updates only on entry to DONE. It keeps the last result in IDLE; the value is undefined for consumers when out_valid=0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers 0.
- Let n = max(1, ceil((msb_index(a)+1)/DIGIT)).
  - Acceptance edge = cycle 0.
  - out_valid rises after edge n; the first cycle with out_valid=1 is cycle n.
  - Worst case n = WIDTH/DIGIT.
- Earliest next acceptance is the cycle after the output handshake edge.
- Throughput: 1 product per n+2 cycles with out_ready held high.
- Inputs a/b are sampled only on the acceptance edge. Later changes are ignored.
- Asserting rst_n low mid-RUN or mid-DONE aborts the operation immediately (asynchronous). No output handshake occurs, and the aborted operation produces no product on rst_n release.
- in_valid held without acceptance is not an error. a/b may change while in_ready=0.

## Structure
- Package rpm_pkg holds:
  - rpm_state_t enum (IDLE, RUN, DONE);
  - constant for legal DIGIT values;
  - elaboration-time check function (WIDTH % DIGIT == 0).
- Sub-module rpm_digit_adder: combinational, parametrised by WIDTH and DIGIT.
  - Inputs: acc, mcand, mplier[DIGIT-1:0].
  - Output: acc + selected partial products, built from the team's CLA carry-chain style.
- The top holds the FSM, shift registers and handshake.

## Test plan
- WIDTH=8, DIGIT=1, a=13, b=11, out_ready=1 -> product=143, out_valid first high 4 cycles after acceptance, busy high throughout.
- WIDTH=8, DIGIT=1, a=255, b=255 -> product=65025 after 8 cycles; a=0, b=200 -> product=0 after 1 cycle.
- WIDTH=16, DIGIT=2, a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 after 8 cycles; a=3, b=5 -> 15 after 1 cycle.
- Backpressure: a=7, b=9, out_ready=0 for 5 cycles after out_valid -> product=63 stable, out_valid held, in_ready=0 and new in_valid ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-run: WIDTH=8, DIGIT=1, a=200, b=3, rst_n low 2 cycles after acceptance -> all outputs at reset values, no out_valid. A follow-up a=3, b=5 -> 15 after 2 cycles.
- Random sweep, all legal DIGIT values at WIDTH=8 and 16, random out_ready:
  - product equals a*b;
  - cycle count equals n;
  - no handshake violations.

Source files
------------

// File: rtl/russian_peasant_seq_multiplier_pkg.sv
// Shared types and configuration checks for the Russian-peasant sequential multiplier.
package rpm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rpm_state_t;

  // Bit d set means DIGIT = d is a supported step size (1, 2 or 4).
  localparam logic [7:0] RPM_LEGAL_DIGITS = 8'b0001_0110;

  function automatic bit rpm_cfg_ok(input int width, input int digit);
    if (width < 2 || digit < 1 || digit > 4) return 1'b0;
    return RPM_LEGAL_DIGITS[digit[2:0]] && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/russian_peasant_seq_multiplier_digit_adder.sv
// Adds the DIGIT selected partial products (mcand << i where mplier[i] is set) to the
// accumulator through a chain of generate/propagate carry adders.
module rpm_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [DIGIT-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] sum_o
);

  localparam int PW = 2 * WIDTH;
  typedef logic [PW-1:0] word_t;

  // Carry-out of the top bit is dropped: the accumulator wraps mod 2^PW.
  function automatic word_t gp_add(input word_t x, input word_t y);
    word_t          g;
    word_t          p;
    logic [PW-1:0]  c;
    g    = x & y;
    p    = x ^ y;
    c[0] = 1'b0;
    for (int i = 0; i < PW - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c;
  endfunction

  word_t sum;

  always_comb begin
    // NOTE: sum gets its default before the loop, so no path leaves it unassigned (no latch).
    sum = acc_i;
    for (int i = 0; i < DIGIT; i++) begin
      if (mplier_i[i]) sum = gp_add(sum, mcand_i << i);
    end
  end

  assign sum_o = sum;

endmodule

// File: rtl/russian_peasant_seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: retires DIGIT multiplier bits per cycle,
// stops as soon as the remaining multiplier is zero, valid/ready on both sides.
module russian_peasant_seq_multiplier
  import rpm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  if (!rpm_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("russian_peasant_seq_multiplier: illegal WIDTH/DIGIT combination");
  end

  rpm_state_t       state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    product_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    mcand_d;
  logic [WIDTH-1:0] mplier_d;

  rpm_digit_adder #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q[DIGIT-1:0]),
    .sum_o    (acc_d)
  );

  assign mcand_d  = mcand_q << DIGIT;
  assign mplier_d = mplier_q >> DIGIT;

  // Flag outputs are kept as registers alongside the state so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so an aborted run leaves no stale operands.
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= '0;
            mcand_q    <= {{WIDTH{1'b0}}, b};
            mplier_q   <= a;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          if (mplier_d == '0) begin
            state_q     <= DONE;
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_russian_peasant_seq_multiplier.sv
// Scoreboard bench: one DUT per WIDTH/DIGIT configuration, drivers push expectations,
// monitors pop and compare whenever out_valid rises and check the handshake every cycle.
module tb_russian_peasant_seq_multiplier;

  localparam int NCFG = 6;
  localparam int NVEC = 11;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    logic        wide;
  } vec_t;

  typedef struct {
    logic [63:0] p;
    int          n;
    longint      t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input int cfg, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, exp);
    end
  endtask

  function automatic int cfg_width(input int i);
    return (i < 3) ? 8 : 16;
  endfunction

  function automatic int cfg_digit(input int i);
    case (i % 3)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Hand-computed directed vectors; wide ones only run on 16-bit configurations.
  function automatic vec_t get_vec(input int i);
    case (i)
      0:       return '{16'd13,    16'd11,    32'd143,        1'b0};
      1:       return '{16'd255,   16'd255,   32'd65025,      1'b0};
      2:       return '{16'd0,     16'd200,   32'd0,          1'b0};
      3:       return '{16'd7,     16'd9,     32'd63,         1'b0};
      4:       return '{16'd3,     16'd5,     32'd15,         1'b0};
      5:       return '{16'd1,     16'd1,     32'd1,          1'b0};
      6:       return '{16'd128,   16'd2,     32'd256,        1'b0};
      7:       return '{16'd200,   16'd0,     32'd0,          1'b0};
      8:       return '{16'hFFFF,  16'hFFFF,  32'hFFFE_0001,  1'b1};
      9:       return '{16'h1234,  16'h0100,  32'h0012_3400,  1'b1};
      default: return '{16'h8000,  16'h0003,  32'h0001_8000,  1'b1};
    endcase
  endfunction

  // Expected cycle count: max(1, ceil((msb_index(a)+1)/d)).
  function automatic int exp_n(input logic [15:0] av, input int w, input int d);
    int m;
    int n;
    m = -1;
    for (int i = 0; i < w; i++) if (av[i]) m = i;
    n = (m + 1 + d - 1) / d;
    return (n < 1) ? 1 : n;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : blk
    localparam int W = cfg_width(g);
    localparam int D = cfg_digit(g);

    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;
    exp_t           q[$];
    bit             done;

    russian_peasant_seq_multiplier #(
      .WIDTH (W),
      .DIGIT (D)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
    );

    task automatic send(input logic [15:0] av, input logic [15:0] bv,
                        input logic [63:0] pv, input bit push);
      int budget;
      budget = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a        = av[W-1:0];
      b        = bv[W-1:0];
      while (!in_ready && budget < 300) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        check(g, "accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
      end else begin
        @(posedge clk);
        if (push) q.push_back('{p: pv, n: exp_n(av, W, D), t0: longint'($time)});
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~a;
        b        = ~b;
      end
    endtask

    task automatic wait_idle(input bit rnd);
      int k;
      k = 0;
      while ((q.size() != 0 || !in_ready) && k < 400) begin
        @(negedge clk);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        k++;
      end
      if (k >= 400) begin
        check(g, "drain_pending", 64'(q.size()), 64'd0);
        check(g, "drain_in_ready", 64'(in_ready), 64'd1);
      end
      out_ready = 1'b1;
    endtask

    // Driver
    initial begin
      vec_t v;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #12;
      check(g, "rst_in_ready", 64'(in_ready), 64'd1);
      check(g, "rst_out_valid", 64'(out_valid), 64'd0);
      check(g, "rst_busy", 64'(busy), 64'd0);
      check(g, "rst_product", 64'(product), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
        v = get_vec(i);
        if (!v.wide || W == 16) begin
          send(v.a, v.b, 64'(v.p), 1'b1);
          wait_idle(1'b0);
        end
      end

      // Backpressure: result held while out_ready is low, new requests ignored.
      begin
        int k;
        out_ready = 1'b0;
        send(16'd7, 16'd9, 64'd63, 1'b1);
        k = 0;
        while (!out_valid && k < 100) begin
          @(negedge clk);
          k++;
        end
        check(g, "bp_out_valid_rise", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        a        = W'(1);
        b        = W'(1);
        repeat (5) begin
          @(negedge clk);
          check(g, "bp_in_ready", 64'(in_ready), 64'd0);
          check(g, "bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check(g, "bp_idle_in_ready", 64'(in_ready), 64'd1);
        check(g, "bp_idle_out_valid", 64'(out_valid), 64'd0);
      end

      // Reset in the middle of a run: nothing may come out afterwards.
      send(16'd200, 16'd3, 64'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check(g, "abort_in_ready", 64'(in_ready), 64'd1);
      check(g, "abort_out_valid", 64'(out_valid), 64'd0);
      check(g, "abort_busy", 64'(busy), 64'd0);
      check(g, "abort_product", 64'(product), 64'd0);
      repeat (2) @(negedge clk);
      check(g, "abort_hold_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      send(16'd3, 16'd5, 64'd15, 1'b1);
      wait_idle(1'b0);

      // Random sweep with random consumer backpressure.
      for (int k = 0; k < 20; k++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [63:0] pe;
        int          sh;
        sh = $urandom_range(0, W);
        ra = 16'($urandom) & 16'((32'h1 << sh) - 32'h1);
        rb = 16'($urandom) & 16'((32'h1 << W) - 32'h1);
        pe = {48'b0, ra} * {48'b0, rb};
        send(ra, rb, pe, 1'b1);
        wait_idle(1'b1);
      end

      repeat (3) @(negedge clk);
      done = 1'b1;
    end

    // Monitor
    initial begin
      logic        ov_prev;
      logic [63:0] cur_p;
      exp_t        e;
      int          n_meas;
      ov_prev = 1'b0;
      cur_p   = '0;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          check(g, "busy_vs_in_ready", 64'(busy), 64'(!in_ready));
          if (out_valid && !ov_prev) begin
            if (q.size() == 0) begin
              check(g, "spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
              e      = q.pop_front();
              cur_p  = e.p;
              n_meas = int'(($time - e.t0 - 5) / 10);
              check(g, "product", 64'(product), e.p);
              check(g, "latency", 64'(n_meas), 64'(e.n));
            end
          end else if (out_valid) begin
            check(g, "product_hold", 64'(product), cur_p);
          end
          ov_prev = out_valid;
        end else begin
          ov_prev = 1'b0;
        end
      end
    end
  end

  logic all_done;
  assign all_done = blk[0].done && blk[1].done && blk[2].done &&
                    blk[3].done && blk[4].done && blk[5].done;

  initial begin
    fork
      wait (all_done);
      #500_000;
    join_any
    disable fork;
    if (!all_done) check(-1, "global_timeout", 64'(all_done), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
